// File: rtl/adc_spi_capture_if.sv
// Purpose : bundles the ADC pins and the sample handshake of the serial ADC capture block.
// Latency : none, signal bundle only.
// Backpressure: none; the consumer acknowledges a sample with inicio, overrun reports missed reads.
// Ports   : inicio/continuo/datoADC towards the capture block, CS/clk/listo/dato/overrun from it.
// master  = capture block side, slave = ADC + sample consumer side.
interface adc_spi_capture_if #(
    parameter int WIDTH = 22
);
    logic             inicio;
    logic             continuo;
    logic             datoADC;
    logic             CS;
    logic             clk;
    logic             listo;
    logic [WIDTH-1:0] dato;
    logic             overrun;

    modport master (
        input  inicio, continuo, datoADC,
        output CS, clk, listo, dato, overrun
    );

    modport slave (
        output inicio, continuo, datoADC,
        input  CS, clk, listo, dato, overrun
    );
endinterface

// File: rtl/adc_spi_capture.sv
// Purpose : serial ADC front end - drives CS/SCLK, shifts in one frame per conversion, emits signed sample.
// Latency : CS low one cycle after start; listo 1 + 2*FRAME_BITS*SCLK_DIV cycles after start is sampled.
// Backpressure: none; a sample completed before the previous one was acknowledged sets sticky overrun.
// Ports   : clk100MHz (sole clock), reset (sync, active low), bus (adc_spi_capture_if.master).
// Option  : ADC_OFFSET_BIN_EN defined -> offset-binary ADC data; undefined -> straight binary, zero-extended.
module adc_spi_capture #(
    parameter int WIDTH         = 22,
    parameter int FRAME_BITS    = 16,
    parameter int DATA_BITS     = 12,
    parameter int SCLK_DIV      = 50,
    parameter int QUIET_PERIODS = 2
) (
    input  logic                clk100MHz,
    input  logic                reset,
    adc_spi_capture_if.master   bus
);
    localparam int QUIET_CYC = 2 * SCLK_DIV * QUIET_PERIODS;
    localparam int DIV_W     = $clog2(SCLK_DIV);
    localparam int RISE_W    = $clog2(FRAME_BITS);
    localparam int QUIET_W   = $clog2(QUIET_CYC);

    typedef enum logic [1:0] {IDLE, CONV, QUIET} state_t;

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic [RISE_W-1:0]    rise_cnt;
    logic [QUIET_W-1:0]   quiet_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 cs_q;
    logic                 sclk_q;
    logic                 listo_q;
    logic                 overrun_q;
    logic                 unread;
    logic [WIDTH-1:0]     dato_q;

    // Only the last DATA_BITS bits of the frame survive; pad bits fall off the top.
    logic [DATA_BITS-1:0] shift_nxt;
    assign shift_nxt = {shift[DATA_BITS-2:0], bus.datoADC};

    function automatic logic [WIDTH-1:0] format_sample(input logic [DATA_BITS-1:0] d);
`ifdef ADC_OFFSET_BIN_EN
        logic [DATA_BITS-1:0] t;
        t = d;
        t[DATA_BITS-1] = ~d[DATA_BITS-1];
        return {{(WIDTH-DATA_BITS){t[DATA_BITS-1]}}, t};
`else
        return {{(WIDTH-DATA_BITS){1'b0}}, d};
`endif
    endfunction

    always_ff @(posedge clk100MHz) begin
        if (!reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            rise_cnt  <= '0;
            quiet_cnt <= '0;
            shift     <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b1;
            listo_q   <= 1'b0;
            overrun_q <= 1'b0;
            unread    <= 1'b0;
            dato_q    <= '0;
        end else begin
            listo_q <= 1'b0;
            // inicio in any state counts as "sample consumed"; a capture below overrides this.
            if (bus.inicio) begin
                unread <= 1'b0;
            end
            case (state)
                IDLE: begin
                    cs_q   <= 1'b1;
                    sclk_q <= 1'b1;
                    if (bus.inicio || bus.continuo) begin
                        state    <= CONV;
                        div_cnt  <= '0;
                        rise_cnt <= '0;
                    end
                end
                CONV: begin
                    if (cs_q) begin
                        // First CONV cycle after IDLE: assert CS, half-period count starts next cycle.
                        cs_q <= 1'b0;
                    end else if (div_cnt == DIV_W'(SCLK_DIV - 1)) begin
                        div_cnt <= '0;
                        sclk_q  <= ~sclk_q;
                        if (!sclk_q) begin
                            // low->high toggle: sample edge
                            shift <= shift_nxt;
                            if (rise_cnt == RISE_W'(FRAME_BITS - 1)) begin
                                dato_q    <= format_sample(shift_nxt);
                                listo_q   <= 1'b1;
                                cs_q      <= 1'b1;
                                quiet_cnt <= '0;
                                state     <= QUIET;
                                if (unread && !bus.inicio) begin
                                    overrun_q <= 1'b1;
                                end
                                unread <= 1'b1;
                            end else begin
                                rise_cnt <= rise_cnt + RISE_W'(1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                QUIET: begin
                    if (quiet_cnt == QUIET_W'(QUIET_CYC - 1)) begin
                        quiet_cnt <= '0;
                        if (bus.continuo) begin
                            // Back-to-back frame: CS drops now so the period is exactly frame + quiet.
                            state    <= CONV;
                            cs_q     <= 1'b0;
                            div_cnt  <= '0;
                            rise_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        quiet_cnt <= quiet_cnt + QUIET_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.CS      = cs_q;
    assign bus.clk     = sclk_q;
    assign bus.listo   = listo_q;
    assign bus.dato    = dato_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_adc_spi_capture.sv
// Purpose : checks adc_spi_capture at default parameters and a fast sweep configuration.
// Latency : n/a (bench).
// Backpressure: n/a (bench).
`timescale 1ns/1ps
module tb_adc_spi_capture;
    localparam int W  = 22;
    localparam int F0 = 16, DV0 = 50, Q0 = 2;
    localparam int F1 = 14, DV1 = 2,  Q1 = 1;

    logic clk100MHz = 1'b0;
    logic reset     = 1'b0;
    always #5 clk100MHz = ~clk100MHz;

    adc_spi_capture_if #(.WIDTH(W)) bus0 ();
    adc_spi_capture_if #(.WIDTH(W)) bus1 ();

    adc_spi_capture #(.WIDTH(W), .FRAME_BITS(F0), .DATA_BITS(12), .SCLK_DIV(DV0), .QUIET_PERIODS(Q0))
        dut0 (.clk100MHz(clk100MHz), .reset(reset), .bus(bus0));
    adc_spi_capture #(.WIDTH(W), .FRAME_BITS(F1), .DATA_BITS(12), .SCLK_DIV(DV1), .QUIET_PERIODS(Q1))
        dut1 (.clk100MHz(clk100MHz), .reset(reset), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    // Reference model: frame position o counts cycles from the edge where CS falls.
    int          m_act    [2];
    int          m_o      [2];
    bit          m_unread [2];
    logic [15:0] m_frame  [2];
    logic        e_cs [2], e_clk [2], e_listo [2], e_ovr [2];
    logic [W-1:0] e_dato [2];
    logic [15:0] q_frame0 [$];
    logic [15:0] q_frame1 [$];
    int          sclk_rise [2];
    logic        sclk_prev [2];

    function automatic int p_f(input int i); return (i == 0) ? F0 : F1; endfunction
    function automatic int p_d(input int i); return (i == 0) ? DV0 : DV1; endfunction
    function automatic int p_q(input int i); return (i == 0) ? Q0 : Q1; endfunction

    function automatic logic [W-1:0] expect_sample(input logic [11:0] d);
`ifdef ADC_OFFSET_BIN_EN
        return W'(int'(d) - 2048);
`else
        return W'(int'(d));
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int i, input logic rst, input logic ini, input logic con);
        int f, d, q;
        f = p_f(i); d = p_d(i); q = p_q(i);
        e_listo[i] = 1'b0;
        if (!rst) begin
            m_act[i] = 0; m_o[i] = 0; m_unread[i] = 1'b0;
            e_cs[i] = 1'b1; e_clk[i] = 1'b1; e_dato[i] = '0; e_ovr[i] = 1'b0;
            return;
        end
        if (m_act[i] == 0) begin
            if (ini || con) begin
                m_act[i] = 1;
                m_o[i]   = -1;
            end
        end else begin
            m_o[i]++;
            if (m_o[i] == 2 * d * (f + q)) begin
                if (con) m_o[i] = 0;
                else     m_act[i] = 0;
            end
        end
        if (m_act[i] == 1 && m_o[i] == 0) begin
            if (i == 0) begin
                if (q_frame0.size() > 0) m_frame[0] = q_frame0.pop_front();
                else                     m_frame[0] = 16'($urandom);
            end else begin
                if (q_frame1.size() > 0) m_frame[1] = q_frame1.pop_front();
                else                     m_frame[1] = 16'($urandom & 32'h3FFF);
            end
        end
        if (m_act[i] == 1 && m_o[i] >= 0 && m_o[i] < 2 * f * d) begin
            e_cs[i]  = 1'b0;
            e_clk[i] = ((m_o[i] / d) % 2 == 0);
        end else begin
            e_cs[i]  = 1'b1;
            e_clk[i] = 1'b1;
        end
        if (m_act[i] == 1 && m_o[i] == 2 * f * d) begin
            e_listo[i] = 1'b1;
            e_dato[i]  = expect_sample(m_frame[i][11:0]);
            if (m_unread[i] && !ini) e_ovr[i] = 1'b1;
            m_unread[i] = 1'b1;
        end else if (ini) begin
            m_unread[i] = 1'b0;
        end
    endtask

    // ADC behaviour: bit k of the frame (MSB first) is valid around the k-th sample edge.
    function automatic logic adc_bit(input int i);
        int f, d, k;
        f = p_f(i); d = p_d(i);
        if (m_act[i] == 1 && m_o[i] >= 0 && m_o[i] < 2 * f * d) begin
            k = (m_o[i] + d) / (2 * d);
            if (k >= 1) return m_frame[i][f - k];
        end
        return 1'($urandom);
    endfunction

    task automatic wait_listo(input int i, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk100MHz);
            if (((i == 0) ? bus0.listo : bus1.listo) === 1'b1) begin
                at = cyc;
                return;
            end
        end
    endtask

    task automatic one_shot0(input logic [15:0] frame, input logic [W-1:0] want, input string nm);
        int t0, at, r0;
        q_frame0.push_back(frame);
        @(negedge clk100MHz);
        bus0.inicio = 1'b1;
        t0 = cyc + 1;
        r0 = sclk_rise[0];
        @(negedge clk100MHz);
        bus0.inicio = 1'b0;
        wait_listo(0, 2000, at);
        chk({nm, "_seen"}, 64'(at >= 0), 64'd1);
        chk({nm, "_latency"}, 64'(at - t0), 64'd1601);
        chk({nm, "_dato"}, 64'(bus0.dato), 64'(want));
        @(negedge clk100MHz);
        chk({nm, "_rises"}, 64'(sclk_rise[0] - r0), 64'd16);
        repeat (300) @(negedge clk100MHz);
        chk({nm, "_idle_cs"}, 64'(bus0.CS), 64'd1);
        chk({nm, "_idle_rises"}, 64'(sclk_rise[0] - r0), 64'd16);
    endtask

    // Model update on every active edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_o[i] = 0; m_unread[i] = 1'b0; m_frame[i] = '0;
            e_cs[i] = 1'b1; e_clk[i] = 1'b1; e_listo[i] = 1'b0; e_ovr[i] = 1'b0; e_dato[i] = '0;
        end
        forever begin
            @(posedge clk100MHz);
            cyc++;
            model_step(0, reset, bus0.inicio, bus0.continuo);
            model_step(1, reset, bus1.inicio, bus1.continuo);
        end
    end

    // Per-cycle compare, SCLK edge counting and ADC data drive, all on the falling edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            sclk_rise[i] = 0;
            sclk_prev[i] = 1'b1;
        end
        bus0.datoADC = 1'b0;
        bus1.datoADC = 1'b0;
        forever begin
            @(negedge clk100MHz);
            if (cyc > 0) begin
                chk("cycle_dut0", 64'({bus0.CS, bus0.clk, bus0.listo, bus0.overrun, bus0.dato}),
                    64'({e_cs[0], e_clk[0], e_listo[0], e_ovr[0], e_dato[0]}));
                chk("cycle_dut1", 64'({bus1.CS, bus1.clk, bus1.listo, bus1.overrun, bus1.dato}),
                    64'({e_cs[1], e_clk[1], e_listo[1], e_ovr[1], e_dato[1]}));
            end
            if (bus0.clk === 1'b1 && sclk_prev[0] === 1'b0) sclk_rise[0]++;
            if (bus1.clk === 1'b1 && sclk_prev[1] === 1'b0) sclk_rise[1]++;
            sclk_prev[0] = bus0.clk;
            sclk_prev[1] = bus1.clk;
            bus0.datoADC = adc_bit(0);
            bus1.datoADC = adc_bit(1);
        end
    end

    // Main sequence on the default-parameter instance.
    initial begin
        int t1, t2, t3, t4, r0;
        bus0.inicio   = 1'b1;
        bus0.continuo = 1'b0;
        repeat (4) @(negedge clk100MHz);
        chk("reset_state", 64'({bus0.CS, bus0.clk, bus0.listo, bus0.overrun, bus0.dato}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 22'h0}));
        reset       = 1'b1;
        bus0.inicio = 1'b0;

`ifdef ADC_OFFSET_BIN_EN
        one_shot0(16'h0ABC, 22'd700,    "oneshot_abc");
        one_shot0(16'h5FFF, 22'd2047,   "oneshot_fff");
        one_shot0(16'hA000, 22'h3FF800, "oneshot_000");
`else
        one_shot0(16'h0ABC, 22'd2748,   "oneshot_abc");
        one_shot0(16'h5FFF, 22'd4095,   "oneshot_fff");
        one_shot0(16'hA000, 22'd0,      "oneshot_000");
`endif

        // Continuous run; the start inicio also consumes the last one-shot sample.
        q_frame0.push_back(16'h3100);
        q_frame0.push_back(16'hC200);
        q_frame0.push_back(16'h0300);
        @(negedge clk100MHz);
        bus0.continuo = 1'b1;
        bus0.inicio   = 1'b1;
        @(negedge clk100MHz);
        bus0.inicio = 1'b0;
        wait_listo(0, 2000, t1);
        chk("cont1_seen", 64'(t1 >= 0), 64'd1);
        chk("cont1_dato", 64'(bus0.dato), 64'(expect_sample(12'h100)));
        chk("cont1_overrun", 64'(bus0.overrun), 64'd0);
        wait_listo(0, 2000, t2);
        chk("cont2_period", 64'(t2 - t1), 64'd1800);
`ifdef ADC_OFFSET_BIN_EN
        chk("cont2_dato", 64'(bus0.dato), 64'h3FFA00);
`else
        chk("cont2_dato", 64'(bus0.dato), 64'd512);
`endif
        chk("cont2_overrun", 64'(bus0.overrun), 64'd1);
        wait_listo(0, 2000, t3);
        chk("cont3_period", 64'(t3 - t2), 64'd1800);
        chk("cont3_dato", 64'(bus0.dato), 64'(expect_sample(12'h300)));
        // Drop continuo mid-frame: the current frame completes, then the block goes idle.
        repeat (800) @(negedge clk100MHz);
        bus0.continuo = 1'b0;
        wait_listo(0, 2000, t4);
        chk("cont4_period", 64'(t4 - t3), 64'd1800);
        r0 = sclk_rise[0];
        repeat (600) @(negedge clk100MHz);
        chk("cont_stop_cs", 64'(bus0.CS), 64'd1);
        chk("cont_stop_rises", 64'(sclk_rise[0] - r0), 64'd0);

        // Reset in the middle of a frame.
        q_frame0.push_back(16'($urandom));
        @(negedge clk100MHz);
        bus0.inicio = 1'b1;
        r0 = sclk_rise[0];
        @(negedge clk100MHz);
        bus0.inicio = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (sclk_rise[0] - r0 >= 8) break;
            @(negedge clk100MHz);
        end
        chk("midreset_reached", 64'(sclk_rise[0] - r0 >= 8), 64'd1);
        reset = 1'b0;
        @(negedge clk100MHz);
        reset = 1'b1;
        chk("midreset_state", 64'({bus0.CS, bus0.clk, bus0.listo, bus0.overrun, bus0.dato}),
            64'({1'b1, 1'b1, 1'b0, 1'b0, 22'h0}));
`ifdef ADC_OFFSET_BIN_EN
        one_shot0(16'h95A5, 22'h3FFDA5, "after_reset");
`else
        one_shot0(16'h95A5, 22'h0005A5, "after_reset");
`endif

        done = 1'b1;
        repeat (5) @(negedge clk100MHz);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Sweep instance: fast SCLK, 14-bit frame with two pad bits, then random traffic.
    initial begin
        int t1, t2, r0, r1;
        bus1.inicio   = 1'b0;
        bus1.continuo = 1'b0;
        q_frame1.push_back(16'h3ABC);
        q_frame1.push_back(16'h1123);
        repeat (6) @(negedge clk100MHz);
        bus1.continuo = 1'b1;
        r0 = sclk_rise[1];
        wait_listo(1, 200, t1);
        chk("sweep1_seen", 64'(t1 >= 0), 64'd1);
`ifdef ADC_OFFSET_BIN_EN
        chk("sweep1_dato", 64'(bus1.dato), 64'd700);
`else
        chk("sweep1_dato", 64'(bus1.dato), 64'd2748);
`endif
        @(negedge clk100MHz);
        r1 = sclk_rise[1];
        chk("sweep1_rises", 64'(r1 - r0), 64'd14);
        wait_listo(1, 200, t2);
        chk("sweep2_period", 64'(t2 - t1), 64'd60);
`ifdef ADC_OFFSET_BIN_EN
        chk("sweep2_dato", 64'(bus1.dato), 64'h3FF923);
`else
        chk("sweep2_dato", 64'(bus1.dato), 64'd291);
`endif
        @(negedge clk100MHz);
        chk("sweep2_rises", 64'(sclk_rise[1] - r1), 64'd14);
        while (!done) begin
            @(negedge clk100MHz);
            bus1.inicio = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 500) == 0) bus1.continuo = ~bus1.continuo;
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d, required below 50000", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/adc_spi_capture.md
# adc_spi_capture

Parametrised serial-ADC front end: generates chip-select and serial clock from the 100 MHz system clock, shifts in one frame per conversion, strips the leading pad bits, and presents the sample as a signed WIDTH-bit word for the downstream filter datapath. Successor to the fixed 12-bit/44 kHz capture chain. Adds configurable frame/data width, SCLK rate, inter-frame quiet time, continuous free-running mode and an overrun flag.

## Interface
- WIDTH, 22: output sample width; must be ≥ DATA_BITS+1
- FRAME_BITS, 16: SCLK periods per conversion frame
- DATA_BITS, 12: valid data bits, the last DATA_BITS of the frame
- SCLK_DIV, 50: clk100MHz cycles per SCLK half-period, ≥ 2 (50 → 1 MHz SCLK)
- QUIET_PERIODS, 2: SCLK periods with CS high between frames, ≥ 1
- clk100MHz  in  1  system clock, sole clock domain
- reset  in  1  synchronous, active-low reset
- inicio  in  1  start request, sampled each cycle
- continuo  in  1  1 = free-running conversions, 0 = one-shot
- datoADC  in  1  serial data from ADC, MSB first
- CS  out  1  ADC chip select, active low
- clk  out  1  serial clock to ADC, idles high
- listo  out  1  one-cycle pulse: new sample on dato
- dato  out  WIDTH  signed sample, held until next listo
- overrun  out  1  sticky: sample completed while previous unread

## Operation
- Reset (reset=0 at a rising edge): state IDLE, CS=1, clk=1, listo=0, dato=0, overrun=0, all counters 0. Applies mid-frame: frame abandoned, no listo.
- States: IDLE → CONV → QUIET → (CONV if continuo=1, else IDLE).
- IDLE: CS=1, clk=1. inicio=1 or continuo=1 → CONV.
- CONV: CS=0. Half-period counter counts 0..SCLK_DIV-1; at each wrap clk toggles. First toggle is high→low. datoADC sampled into shift register (shift left, LSB in) on every clk low→high toggle. After FRAME_BITS rising edges: capture, → QUIET.
- Capture: d = shift[DATA_BITS-1:0]; leading FRAME_BITS-DATA_BITS bits discarded unchecked. dato updated per Configuration; listo=1 for one cycle.
- QUIET: CS=1, clk=1 for QUIET_PERIODS×2×SCLK_DIV cycles; then continuo sampled at exit.
- inicio ignored outside IDLE. Dropping continuo mid-frame completes the current frame, then IDLE.
- Read acknowledge: overrun set if a capture occurs while the previous listo was not followed by inicio=1 in continuous mode; implementers treat inicio=1 in any state as "sample consumed". Cleared only by reset.

## Timing
- inicio sampled high in IDLE at edge N → CS=0 from edge N+1.
- First clk falling edge at N+1+SCLK_DIV; k-th sample edge at N+1+(2k)×SCLK_DIV, k=1..FRAME_BITS.
- listo high and dato valid from edge N+1+2×FRAME_BITS×SCLK_DIV (same edge CS returns high), for one cycle.
- Continuous frame period: 2×SCLK_DIV×(FRAME_BITS+QUIET_PERIODS) cycles; defaults 1800 cycles → 55.56 kS/s.
- CS, clk, listo, dato, overrun all registered outputs; no combinational path from inputs.

## Configuration
- ADC_OFFSET_BIN_EN defined: ADC output treated as offset binary; dato = sign-extension of {~d[DATA_BITS-1], d[DATA_BITS-2:0]} (0x800 → 0, 0xFFF → +2047, 0x000 → −2048).
- Undefined: straight binary; dato = zero-extension of d (0x800 → 2048, 0xFFF → 4095), always non-negative.

## Test plan
- Reset: hold reset=0 4 cycles with inicio=1, datoADC toggling → CS=1, clk=1, listo=0, dato=0, overrun=0 throughout.
- One-shot, defaults, frame 0x0ABC driven on datoADC → exactly 16 clk rising edges, listo one pulse at start+1+1600, dato=2748 (macro off) / 700 (macro on); then IDLE, CS stays 1.
- Offset extremes with ADC_OFFSET_BIN_EN: data 0xFFF → dato=2047; 0x000 → dato=−2048 (0x3FF800 at WIDTH=22).
- Continuous: continuo=1, three frames 0x100,0x200,0x300 → listo pulses 1800 cycles apart, dato follows each; no inicio given → overrun=1 after second capture.
- Reset mid-frame: reset=0 at 8th sample edge → CS=1, clk=1 next edge, no listo; inicio afterward yields a clean full frame.
- Parameter sweep: FRAME_BITS=14, DATA_BITS=12, SCLK_DIV=2, QUIET_PERIODS=1 → 14 rising edges per frame, period 60 cycles, pad bits ignored.
